// File: rtl/rr_arbiter_4.sv
// Four-way round-robin bus arbiter with a hold limit: grant follows a sampled request by one cycle.
// A requester keeps the bus until done, request drop, or MAX_HOLD cycles, and each release inserts one idle cycle.
module rr_arbiter_4 #(
   parameter int MAX_HOLD = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [3:0]  done,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [31:0] data3,
   output logic [3:0]  grant,
   output logic [1:0]  sel,
   output logic [31:0] bus_out,
   output logic        bus_valid,
   output logic        timeout
);

   localparam int CNT_W = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_q,    state_d;
   logic [3:0]         grant_q,    grant_d;
   logic [1:0]         sel_q,      sel_d;
   logic [1:0]         ptr_q,      ptr_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic               timeout_q,  timeout_d;

   logic               pick_vld;
   logic [1:0]         pick_idx;
   logic [1:0]         cand;
   logic               rel_owner;
   logic               rel_limit;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      pick_vld   = 1'b0;
      pick_idx   = ptr_q;
      cand       = ptr_q;

      // Scan from the pointer upward; the first requester found wins.
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end

      rel_owner = done[sel_q] | ~req[sel_q];
      rel_limit = (hold_cnt_q == HOLD_LAST);

      case (state_q)
         IDLE: begin
            grant_d = 4'b0000;
            if (pick_vld) begin
               state_d    = BUSY;
               grant_d    = 4'b0001 << pick_idx;
               sel_d      = pick_idx;
               hold_cnt_d = '0;
            end
         end
         BUSY: begin
            if (rel_owner || rel_limit) begin
               state_d    = IDLE;
               grant_d    = 4'b0000;
               ptr_d      = sel_q + 2'd1;
               hold_cnt_d = '0;
               // A limit release only counts as a timeout if the owner was not leaving anyway.
               timeout_d  = rel_limit & ~rel_owner;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= 4'b0000;
         sel_q      <= 2'd0;
         ptr_q      <= 2'd0;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      bus_out = 32'h0;
      if (state_q == BUSY) begin
         case (sel_q)
            2'd0:    bus_out = data0;
            2'd1:    bus_out = data1;
            2'd2:    bus_out = data2;
            default: bus_out = data3;
         endcase
      end
   end

   assign grant     = grant_q;
   assign sel       = sel_q;
   assign bus_valid = (state_q == BUSY);
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboarded directed bench: two arbiters (MAX_HOLD 16 and 4) share stimulus, each with its own expectations.
module tb_rr_arbiter_4;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [3:0]  done;
   logic [31:0] data0, data1, data2, data3;

   logic [3:0]  a_grant,  b_grant;
   logic [1:0]  a_sel,    b_sel;
   logic [31:0] a_bus,    b_bus;
   logic        a_valid,  b_valid;
   logic        a_to,     b_to;

   always #5 clock = ~clock;

   rr_arbiter_4 u_dut_a (
      .clock(clock), .reset(reset), .req(req), .done(done),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .grant(a_grant), .sel(a_sel), .bus_out(a_bus), .bus_valid(a_valid), .timeout(a_to)
   );

   rr_arbiter_4 #(.MAX_HOLD(4)) u_dut_b (
      .clock(clock), .reset(reset), .req(req), .done(done),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .grant(b_grant), .sel(b_sel), .bus_out(b_bus), .bus_valid(b_valid), .timeout(b_to)
   );

   typedef struct {
      bit         chk_a;
      logic [3:0] g_a;
      logic [1:0] s_a;
      logic       t_a;
      bit         chk_b;
      logic [3:0] g_b;
      logic [1:0] s_b;
      logic       t_b;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic logic [31:0] bus_of(input logic [3:0] g, input logic [1:0] s);
      if (g == 4'b0000) return 32'h0;
      case (s)
         2'd0:    return data0;
         2'd1:    return data1;
         2'd2:    return data2;
         default: return data3;
      endcase
   endfunction

   task automatic check(input string nm, input string which,
                        input logic [3:0] ag, input logic [1:0] a_s, input logic [31:0] ab,
                        input logic av, input logic at,
                        input logic [3:0] eg, input logic [1:0] es, input logic et);
      logic [31:0] eb;
      logic        ev;
      eb = bus_of(eg, es);
      ev = |eg;
      tests++;
      if ({ag, a_s, ab, av, at} !== {eg, es, eb, ev, et}) begin
         fails++;
         $display("FAIL %s[%s]: got grant=%b sel=%0d bus=%h valid=%b timeout=%b, expected grant=%b sel=%0d bus=%h valid=%b timeout=%b",
                  nm, which, ag, a_s, ab, av, at, eg, es, eb, ev, et);
      end
   endtask

   // Inputs change on the falling edge; the pushed entry describes outputs after the next rising edge.
   task automatic cyc2(input bit rst, input logic [3:0] r, input logic [3:0] d,
                       input bit ca, input logic [3:0] ga, input logic [1:0] sa, input logic ta,
                       input bit cb, input logic [3:0] gb, input logic [1:0] sb_, input logic tb_,
                       input string nm);
      exp_t e;
      @(negedge clock);
      reset = rst;
      req   = r;
      done  = d;
      e.chk_a = ca; e.g_a = ga; e.s_a = sa;  e.t_a = ta;
      e.chk_b = cb; e.g_b = gb; e.s_b = sb_; e.t_b = tb_;
      e.name  = nm;
      sb.push_back(e);
   endtask

   task automatic cyc(input bit rst, input logic [3:0] r, input logic [3:0] d,
                      input logic [3:0] g, input logic [1:0] s, input logic t, input string nm);
      cyc2(rst, r, d, 1'b1, g, s, t, 1'b1, g, s, t, nm);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.chk_a) check(e.name, "H16", a_grant, a_sel, a_bus, a_valid, a_to, e.g_a, e.s_a, e.t_a);
            if (e.chk_b) check(e.name, "H4",  b_grant, b_sel, b_bus, b_valid, b_to, e.g_b, e.s_b, e.t_b);
         end
      end
   end

   initial begin : stim
      reset = 1'b1;
      req   = 4'b0000;
      done  = 4'b0000;
      data0 = 32'h1111_0000;
      data1 = 32'h2222_0001;
      data2 = 32'hDEAD_BEEF;
      data3 = 32'h4444_0003;

      // Reset, then full-request round robin with done on each grant's second cycle.
      cyc(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "rst_state");
      cyc(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, "rst_override");
      cyc(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rr_g0_c1");
      cyc(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rr_g0_c2");
      cyc(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, "rr_idle0");
      cyc(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0, "rr_g1_c1");
      cyc(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0, "rr_g1_c2");
      cyc(0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 0, "rr_idle1");
      cyc(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0, "rr_g2_c1");
      cyc(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0, "rr_g2_c2");
      cyc(0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 0, "rr_idle2");
      cyc(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0, "rr_g3_c1");
      cyc(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0, "rr_g3_c2");
      cyc(0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 0, "rr_idle3");
      cyc(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rr_g0b_c1");
      cyc(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rr_g0b_c2");
      cyc(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, "rr_idle4");

      // Single request 2 from pointer 0; dropping req releases and sel holds.
      cyc(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "rst2");
      cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "single_req2");
      cyc(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "drop_release");
      cyc(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "idle_sel_hold");

      // Owner 3 releases with req 1001: pointer wraps to 0.
      cyc(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 0, "own3");
      cyc(0, 4'b1001, 4'b1000, 4'b0000, 2'd3, 0, "own3_done");
      cyc(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 0, "wrap_to0");
      cyc(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "wrap_release");

      // Other requesters' done/req activity leaves the owner alone.
      cyc(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "own1");
      cyc(0, 4'b1011, 4'b1101, 4'b0010, 2'd1, 0, "foreign_done");
      cyc(0, 4'b0011, 4'b0001, 4'b0010, 2'd1, 0, "foreign_req");
      cyc(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, "own1_release");

      // Requester 1 holds forever: the MAX_HOLD=4 copy times out, then re-grants after one idle cycle.
      cyc(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "hold_c1");
      cyc(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "hold_c2");
      cyc(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "hold_c3");
      cyc(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "hold_c4");
      cyc2(0, 4'b0010, 4'b0000, 1, 4'b0010, 2'd1, 0, 1, 4'b0000, 2'd1, 1, "timeout_pulse");
      cyc2(0, 4'b0010, 4'b0000, 1, 4'b0010, 2'd1, 0, 1, 4'b0010, 2'd1, 0, "regrant_after_to");
      cyc(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, "hold_release");

      // done coincides with the hold limit: release without timeout.
      cyc(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "rst3");
      cyc(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "lim_c1");
      cyc(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "lim_c2");
      cyc(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "lim_c3");
      cyc(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "lim_c4");
      cyc(0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 0, "done_at_limit");

      // Timeout with a higher-priority requester waiting hands the bus to it.
      cyc(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "to2_c1");
      cyc(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "to2_c2");
      cyc(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "to2_c3");
      cyc(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "to2_c4");
      cyc2(0, 4'b0011, 4'b0000, 1, 4'b0001, 2'd0, 0, 1, 4'b0000, 2'd0, 1, "to2_pulse");
      cyc2(0, 4'b0011, 4'b0000, 1, 4'b0001, 2'd0, 0, 1, 4'b0010, 2'd1, 0, "to2_next_owner");

      // Reset in the middle of a long grant (owner 2, hold_cnt 5 in the MAX_HOLD=16 copy).
      cyc(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "rst4");
      cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "mid_c1");
      cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "mid_c2");
      cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "mid_c3");
      cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "mid_c4");
      cyc2(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 0, 1, 4'b0000, 2'd2, 1, "mid_c5");
      cyc2(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 0, 1, 4'b0100, 2'd2, 0, "mid_c6");
      cyc(1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0, "rst_mid_busy");
      cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "regrant_after_rst");
      cyc(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "final_release");

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
      @(posedge clock);
      #3;
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, maximum consecutive cycles one requester may hold the grant (legal range 2..256).
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  4  req[i] high = requester i wants the shared bus.
REQ-005 SHALL have port done  input  4  done[i] high = requester i releases the bus this cycle.
REQ-006 SHALL have ports data0, data1, data2, data3  input  32 each  requester data words.
REQ-007 SHALL have port grant  output  4  one-hot grant, registered.
REQ-008 SHALL have port sel  output  2  binary index of the current owner, registered; drives the shared 4:1 32-bit select.
REQ-009 SHALL have port bus_out  output  32  the selected data word.
REQ-010 SHALL have port bus_valid  output  1  high while a grant is held.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner = sel).
REQ-013 SHALL hold a 2-bit round-robin pointer ptr; priority order ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-014 In IDLE, if any req is high, SHALL select the first requester in priority order and, at the next edge, enter BUSY with grant one-hot at that index, sel = index, hold_cnt = 0.
REQ-015 In IDLE with req = 0, SHALL stay in IDLE with grant = 0; sel SHALL hold its last value.
REQ-016 Grant latency SHALL be exactly one cycle from a req sampled high in IDLE to grant high.
REQ-017 In BUSY, hold_cnt SHALL increment by 1 each cycle the grant is kept.
REQ-018 In BUSY, release SHALL occur when done[sel] = 1, req[sel] = 0, or hold_cnt = MAX_HOLD-1. At that edge: return to IDLE, grant = 0, ptr = sel+1 mod 4 (3 wraps to 0).
REQ-019 A grant SHALL therefore last at most MAX_HOLD cycles, and every release SHALL be followed by exactly one IDLE cycle with grant = 0 before the next grant.
REQ-020 timeout SHALL pulse high for the one cycle after a release caused only by hold_cnt = MAX_HOLD-1; it SHALL NOT pulse if done[sel] or !req[sel] is true in the same cycle.
REQ-021 done[i] and req[i] changes for i != sel SHALL NOT affect the current grant.
REQ-022 bus_out SHALL equal data[sel] when bus_valid = 1 and 32'h0 otherwise (combinational from registered sel/state); bus_valid SHALL be high exactly in BUSY.
REQ-023 grant SHALL never have more than one bit set; sel SHALL equal the index of the set grant bit whenever grant != 0.
REQ-024 Pointer update SHALL make a continuously requesting requester wait at most 3 grants before being served.

Reset
REQ-025 When reset is high at a rising edge, the block SHALL enter IDLE with grant = 0, sel = 0, ptr = 0, hold_cnt = 0, timeout = 0, bus_valid = 0, bus_out = 0, overriding all other inputs, including in BUSY.
REQ-026 After reset deasserts, arbitration SHALL resume at the next edge with requester 0 at highest priority.

Verification
REQ-027 Reset, then req = 4'b1111 held and done pulsed at each grant's second cycle -> grants 0,1,2,3,0 in order, each 2 cycles long, one IDLE cycle between grants.
REQ-028 ptr = 0, req = 4'b0100, data2 = 32'hDEADBEEF -> next cycle grant = 4'b0100, sel = 2, bus_out = 32'hDEADBEEF, bus_valid = 1.
REQ-029 MAX_HOLD = 4, req[1] held and done never asserted -> grant[1] high for exactly 4 cycles, then timeout = 1 for one cycle, then grant[1] again after the IDLE cycle only if no higher-priority req is pending.
REQ-030 Owner 3 releases with req = 4'b1001 -> ptr wraps to 0 and the next grant = 4'b0001.
REQ-031 Reset asserted mid-BUSY (owner 2, hold_cnt = 5) -> next edge grant = 0, sel = 0, bus_out = 0, timeout = 0; with req = 4'b0100 still high, grant = 4'b0100 one cycle after reset deasserts.
REQ-032 MAX_HOLD = 4, done[sel] high in the same cycle as hold_cnt = 3 -> release with timeout remaining 0.
